// File: rtl/pps_gate_counter.sv
// PPS-gated BCD frequency counter. Detects a lost PPS and streams each latched
// count to the UART buffer as an ASCII line: digits, optional '!', CR, LF.
module pps_gate_counter #(
  parameter int DIGITS         = 8,
  parameter int GATE_PPS       = 1,
  parameter int TIMEOUT_CYCLES = 24000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pps,
  input  logic                  tx_ready,
  output logic [7:0]            tx_char,
  output logic                  tx_strobe,
  output logic [4*DIGITS-1:0]   result,
  output logic                  result_valid,
  output logic                  overflow,
  output logic                  pps_lost,
  output logic                  busy
);
  // state  | meaning
  // IDLE   | no frame in flight
  // DIGIT  | sending digit idx, most significant first
  // FLAG   | sending '!' overflow marker
  // CR     | sending carriage return
  // LF     | sending line feed, frame ends
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DIGIT = 3'd1;
  localparam logic [2:0] S_FLAG  = 3'd2;
  localparam logic [2:0] S_CR    = 3'd3;
  localparam logic [2:0] S_LF    = 3'd4;

  localparam int             CW        = 4 * DIGITS;
  localparam int             IW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0]  IDLE_MAX  = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0]  IDLE_PRE  = IW'(TIMEOUT_CYCLES - 2);
  localparam logic [3:0]     GATE_LAST = 4'(GATE_PPS - 1);
  localparam logic [3:0]     DIG_TOP   = 4'(DIGITS - 1);

  logic          pps_s1, pps_s2, pps_s3, edge_q;
  logic [CW-1:0] cnt, cnt_inc;
  logic          cnt_wrap;
  logic          ovf_acc, armed;
  logic [3:0]    gate_cnt;
  logic [IW-1:0] idle_cnt;
  logic          close_gate, arm_now, timeout_hit;

  logic [2:0]    state;
  logic [CW-1:0] snap;
  logic          snap_ovf;
  logic [3:0]    idx;
  logic          start_q;
  logic          issue;
  logic [3:0]    cur_digit;
  logic [7:0]    char_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      pps_s1 <= 1'b0;
      pps_s2 <= 1'b0;
      pps_s3 <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      pps_s1 <= pps;
      pps_s2 <= pps_s1;
      pps_s3 <= pps_s2;
      edge_q <= pps_s2 & ~pps_s3;
    end
  end

  // Decimal ripple increment; carry out of the top digit is the wrap.
  always_comb begin
    logic carry;
    cnt_inc = cnt;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    cnt_wrap = carry;
  end

  assign close_gate  = edge_q && armed && (gate_cnt == GATE_LAST);
  assign arm_now     = edge_q && !armed;
  assign timeout_hit = !edge_q && (idle_cnt == IDLE_PRE);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      ovf_acc      <= 1'b0;
      armed        <= 1'b0;
      gate_cnt     <= 4'd0;
      idle_cnt     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      pps_lost     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (close_gate || arm_now) begin
        cnt      <= CW'(1);
        ovf_acc  <= 1'b0;
        gate_cnt <= 4'd0;
      end else begin
        cnt <= cnt_inc;
        if (cnt_wrap) ovf_acc <= 1'b1;
        if (edge_q) gate_cnt <= gate_cnt + 4'd1;
      end
      if (close_gate) begin
        result       <= cnt;
        overflow     <= ovf_acc;
        result_valid <= 1'b1;
      end
      if (arm_now) begin
        armed    <= 1'b1;
        pps_lost <= 1'b0;
      end
      // idle_cnt saturates so pps_lost stays a clean level until the next edge
      if (edge_q) begin
        idle_cnt <= '0;
      end else if (timeout_hit) begin
        idle_cnt <= IDLE_MAX;
        pps_lost <= 1'b1;
        armed    <= 1'b0;
        gate_cnt <= 4'd0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign issue     = busy && tx_ready && !tx_strobe && !start_q;
  assign cur_digit = 4'(snap >> {idx, 2'b00});

  always_comb begin
    char_next = 8'h00;
    case (state)
      S_DIGIT: char_next = 8'h30 | {4'h0, cur_digit};
      S_FLAG:  char_next = 8'h21;
      S_CR:    char_next = 8'h0D;
      S_LF:    char_next = 8'h0A;
      default: char_next = 8'h00;
    endcase
  end

  // start_q holds off the first character one cycle after a frame is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      snap      <= '0;
      snap_ovf  <= 1'b0;
      idx       <= 4'd0;
      start_q   <= 1'b0;
      tx_strobe <= 1'b0;
      tx_char   <= 8'h00;
    end else begin
      start_q   <= 1'b0;
      tx_strobe <= issue;
      if (issue) tx_char <= char_next;
      case (state)
        S_IDLE: begin
          if (close_gate) begin
            snap     <= cnt;
            snap_ovf <= ovf_acc;
            idx      <= DIG_TOP;
            start_q  <= 1'b1;
            state    <= S_DIGIT;
          end
        end
        S_DIGIT: begin
          if (issue) begin
            if (idx == 4'd0) state <= snap_ovf ? S_FLAG : S_CR;
            else             idx   <= idx - 4'd1;
          end
        end
        S_FLAG:  if (issue) state <= S_CR;
        S_CR:    if (issue) state <= S_LF;
        S_LF:    if (issue) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pps_gate_counter.sv
// Scoreboard bench for pps_gate_counter: stimulus pushes expected results and
// characters, a negedge monitor pops and compares them as the DUT emits.
module tb_pps_gate_counter;
  localparam int D   = 3;
  localparam int G   = 2;
  localparam int T   = 1000;
  localparam int MOD = 10 ** D;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           pps = 1'b0;
  logic           tx_ready = 1'b1;
  logic [7:0]     tx_char;
  logic           tx_strobe;
  logic [4*D-1:0] result;
  logic           result_valid, overflow, pps_lost, busy;

  pps_gate_counter #(.DIGITS(D), .GATE_PPS(G), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .pps(pps), .tx_ready(tx_ready),
    .tx_char(tx_char), .tx_strobe(tx_strobe), .result(result),
    .result_valid(result_valid), .overflow(overflow),
    .pps_lost(pps_lost), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [4*D-1:0] bcd; bit ovf; int cyc; bit frame; } res_t;
  typedef struct { logic [7:0] ch; int cyc; } chr_t;
  res_t exp_res[$];
  chr_t exp_chr[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobes = 0;

  bit m_armed = 0, m_frame_ok = 1, m_timed = 1, rdy_rand = 0;
  int m_gate = 0, m_open = 0, m_prev_e = 0, last_rise = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] b;
    int x;
    x = v;
    b = '0;
    for (int i = 0; i < D; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  // Reference: result is the cycle distance between closing PPS rises.
  task automatic model_edge(input int p);
    res_t r;
    chr_t c;
    int n, k, val;
    if (p - m_prev_e >= T) m_armed = 0;
    m_prev_e = p;
    if (!m_armed) begin
      m_armed = 1;
      m_gate  = 0;
      m_open  = p;
    end else begin
      m_gate++;
      if (m_gate == G) begin
        n       = p - m_open;
        val     = n % MOD;
        r.bcd   = to_bcd(val);
        r.ovf   = (n >= MOD);
        r.cyc   = p + 4;
        r.frame = m_frame_ok;
        exp_res.push_back(r);
        if (m_frame_ok) begin
          k = 0;
          for (int i = D - 1; i >= 0; i--) begin
            c.ch  = 8'h30 + 8'(r.bcd[4*i +: 4]);
            c.cyc = m_timed ? p + 6 + 2 * k : -1;
            exp_chr.push_back(c);
            k++;
          end
          if (r.ovf) begin
            c.ch = 8'h21; c.cyc = m_timed ? p + 6 + 2 * k : -1;
            exp_chr.push_back(c); k++;
          end
          c.ch = 8'h0D; c.cyc = m_timed ? p + 6 + 2 * k : -1;
          exp_chr.push_back(c); k++;
          c.ch = 8'h0A; c.cyc = m_timed ? p + 6 + 2 * k : -1;
          exp_chr.push_back(c);
        end
        m_open = p;
        m_gate = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic pulse(input int gap);
    pps = 1'b1;
    last_rise = cyc;
    model_edge(cyc);
    repeat (2) tick();
    pps = 1'b0;
    repeat (gap - 2) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_res.delete();
    exp_chr.delete();
    m_armed = 0;
    tick();
    @(negedge clk);
    check("rst_tx_char", 64'(tx_char), 64'(0));
    check("rst_tx_strobe", 64'(tx_strobe), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_result_valid", 64'(result_valid), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_pps_lost", 64'(pps_lost), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    tick();
    reset = 1'b0;
    m_prev_e = cyc;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && (exp_res.size() != 0 || exp_chr.size() != 0); i++) tick();
    check("drain_results", 64'(exp_res.size()), 64'(0));
    check("drain_chars", 64'(exp_chr.size()), 64'(0));
  endtask

  res_t mon_r;
  chr_t mon_c;
  logic prev_strobe = 1'b0, prev_rdy = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (result_valid) begin
        if (exp_res.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL result_unexpected: got 0x%0h, expected no result (cycle %0d)", result, cyc);
        end else begin
          mon_r = exp_res.pop_front();
          check("result", 64'(result), 64'(mon_r.bcd));
          check("overflow", 64'(overflow), 64'(mon_r.ovf));
          check("result_cycle", 64'(cyc), 64'(mon_r.cyc));
          if (mon_r.frame) check("busy_with_result", 64'(busy), 64'(1));
        end
      end
      if (tx_strobe) begin
        n_strobes++;
        check("no_back_to_back", 64'(prev_strobe), 64'(0));
        check("ready_before_strobe", 64'(prev_rdy), 64'(1));
        if (exp_chr.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL char_unexpected: got 0x%0h, expected no strobe (cycle %0d)", tx_char, cyc);
        end else begin
          mon_c = exp_chr.pop_front();
          check("tx_char", 64'(tx_char), 64'(mon_c.ch));
          if (mon_c.cyc >= 0) check("strobe_cycle", 64'(cyc), 64'(mon_c.cyc));
          if (mon_c.ch == 8'h0A) check("busy_after_lf", 64'(busy), 64'(0));
        end
      end
    end
    prev_strobe = tx_strobe;
    prev_rdy    = tx_ready;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, n0;

    // basic gates of 200 cycles
    do_reset();
    repeat (5) pulse(100);
    wait_drain();

    // overflow gate then a short clean gate
    do_reset();
    pulse(600); pulse(600); pulse(20); pulse(20); pulse(100);
    wait_drain();

    // second result during a frame is not framed
    do_reset();
    pulse(60); pulse(60); pulse(4); pulse(4);
    m_frame_ok = 0;
    pulse(100);
    m_frame_ok = 1;
    pulse(100); pulse(100);
    wait_drain();

    // backpressure: tx_ready low for 20 cycles mid-frame
    do_reset();
    m_timed = 0;
    fork
      begin
        repeat (5) pulse(100);
      end
      begin
        for (int i = 0; i < 1000 && !result_valid; i++) @(negedge clk);
        repeat (3) tick();
        tx_ready = 1'b0;
        repeat (20) tick();
        tx_ready = 1'b1;
      end
    join
    wait_drain();
    m_timed = 1;

    // PPS loss and recovery
    do_reset();
    pulse(100); pulse(100); pulse(4);
    p = last_rise;
    while (cyc != p + 1002) @(negedge clk);
    check("pps_lost_before_timeout", 64'(pps_lost), 64'(0));
    @(negedge clk);
    check("pps_lost_at_timeout", 64'(pps_lost), 64'(1));
    @(posedge clk); #1;
    pulse(100);
    check("pps_lost_cleared", 64'(pps_lost), 64'(0));
    pulse(100); pulse(100);
    wait_drain();

    // reset after three characters of a frame
    do_reset();
    pulse(100); pulse(100);
    n0 = n_strobes;
    fork
      pulse(60);
      begin
        for (int i = 0; i < 200 && n_strobes < n0 + 3; i++) @(negedge clk);
        check("three_strobes_before_reset", 64'(n_strobes - n0), 64'(3));
        @(posedge clk); #1;
        do_reset();
      end
    join
    pulse(100); pulse(100); pulse(100);
    wait_drain();

    // randomized gates with random tx_ready
    do_reset();
    m_timed  = 0;
    rdy_rand = 1;
    for (int i = 0; i < 24; i++) pulse(int'($urandom_range(60, 700)));
    rdy_rand = 0;
    tx_ready = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pps_gate_counter.md
# pps_gate_counter

Parametrised PPS-gated frequency counter with built-in ASCII framing. It counts `clk` cycles over a gate of `GATE_PPS` PPS periods in a `DIGITS`-wide BCD counter and latches the result with an overflow flag. It detects a lost PPS and streams each result as an ASCII line, with a ready/strobe handshake, into the UART buffer. It sits between the PPS pin and `uart_buffer` in the top level and replaces the hand-wired BCD chain and fixed-width BCD sender.

## Interface
- `DIGITS`, 8: BCD digits in the counter and result, 1..15.
- `GATE_PPS`, 1: PPS periods per gate, 1..15.
- `TIMEOUT_CYCLES`, 24000000: cycles without a PPS edge before `pps_lost` asserts, ≥2.
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  synchronous, active-high.
- `pps`  in  1  asynchronous PPS input.
- `tx_ready`  in  1  downstream can accept a character this cycle.
- `tx_char`  out  8  ASCII character, valid while `tx_strobe`=1.
- `tx_strobe`  out  1  one-cycle character strobe.
- `result`  out  4*DIGITS  last latched BCD count, digit 0 in bits [3:0].
- `result_valid`  out  1  one-cycle pulse when `result` updates.
- `overflow`  out  1  counter wrapped during the gate of the current `result`.
- `pps_lost`  out  1  no PPS edge seen within `TIMEOUT_CYCLES`.
- `busy`  out  1  serializer is emitting a frame.

## Operation
- **PPS input conditioning**
  - `pps` passes through a 2-flop synchronizer, then a rising-edge detect.
  - The edge pulse E is high for one cycle, 3 cycles after `pps` rises at the pin.
- **Counting and gating**
  - C is a DIGITS-digit BCD counter that increments every cycle, with combinational carry between digits.
  - Carry out of the top digit wraps C to 0 and sets sticky `ovf_acc`.
  - `gate_cnt` counts E pulses. A closing edge is an E with `gate_cnt`=GATE_PPS-1, or any E while unarmed.
- **Closing edge while armed**
  - `result` <= C, `overflow` <= `ovf_acc`, `result_valid` pulses.
  - C <= 1, `ovf_acc` <= 0, `gate_cnt` <= 0.
  - The result therefore equals the exact cycle count between closing edges, modulo 10^DIGITS.
- **Closing edge while unarmed** (after reset or after `pps_lost`)
  - Sets armed, C <= 1, `gate_cnt` <= 0, clears `pps_lost`.
  - No result is produced.
- **Timeout**
  - `idle_cnt` is cleared on every E and otherwise increments.
  - When it reaches TIMEOUT_CYCLES-1: `pps_lost` <= 1, armed <= 0, `gate_cnt` <= 0.
  - If E and timeout occur in the same cycle, E wins.
- **Serializer FSM**: states IDLE, DIGIT, FLAG, CR, LF.
  - IDLE: on `result_valid`, snapshot `result` and `overflow`, set digit index to DIGITS-1, go to DIGIT, `busy`=1.
  - DIGIT: send "0"+digit (0x30..0x39), most-significant digit first. After index 0, go to FLAG if overflow, else CR.
  - FLAG: send "!" (0x21), then go to CR.
  - CR: send 0x0D, then go to LF.
  - LF: send 0x0A, then go to IDLE, `busy`=0.
  - `result_valid` while `busy`: the frame is dropped. `result`/`overflow` ports still update; the frame in flight is unaffected.
- **Handshake**
  - In a sending state, a character is issued on the cycle after `tx_ready` is sampled high with no strobe in the previous cycle. That cycle registers `tx_strobe`=1 and `tx_char`, and the FSM advances.
  - Strobes are therefore never back-to-back.
  - While `tx_ready`=0 the FSM holds and emits nothing.

## Timing
- **Reset values**: all outputs 0 (`tx_char`=0x00, `pps_lost`=0, `busy`=0). C=0, unarmed, `gate_cnt`=0, `idle_cnt`=0, FSM in IDLE.
- **Latency**
  - `result_valid`/`result`/`overflow` update in the cycle after E.
  - `busy` rises with that update.
  - With `tx_ready` held high, the first `tx_strobe` comes 2 cycles after `result_valid`. Further strobes follow every 2 cycles.
  - Frame length is DIGITS+2 characters, or DIGITS+3 with the flag.
- **Reset mid-frame**: the FSM returns to IDLE immediately. No partial continuation; the next result requires re-arming.
- **Timeout**: `pps_lost` rises TIMEOUT_CYCLES cycles after the last E (with no intervening E) and is level-held until the next E.
- **Width rule**: C and `result` are exactly 4*DIGITS bits; there are no binary intermediates.

## Test plan
- **Basic count**: DIGITS=8, GATE_PPS=1, E every 100 cycles → first E gives no output. Second E → `result`=0x00000100, `overflow`=0, frame "00000100",0x0D,0x0A.
- **Multi-period gate**: GATE_PPS=3, E every 50 cycles → after the arming E, each third E gives `result`=0x00000150.
- **Overflow**: DIGITS=2, E every 105 cycles → `result`=0x05, `overflow`=1, frame "05!",0x0D,0x0A. The next gate of 40 cycles → 0x40, `overflow`=0.
- **PPS loss**: TIMEOUT_CYCLES=1000, E stops → `pps_lost`=1 exactly 1000 cycles after the last E. The next E clears it with no result; the following E (100 later) gives 0x00000100.
- **Backpressure and drop**
  - Drive `tx_ready` low for 20 cycles mid-frame → no strobes while low, character order intact, never back-to-back strobes.
  - A second result during the frame → `result` updates and no second frame is sent.
- **Reset mid-frame**: assert `reset` after 3 characters → all outputs at reset values the next cycle and no further strobes. After release, the first E arms only.
